// File: rtl/matmul_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : matmul_dot_accumulator
// Purpose  : Sums K_LEN unsigned products into one saturating result per
//            output element, presented on a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_dot_accumulator #(
    parameter int PROD_WIDTH = 61,
    parameter int ACC_WIDTH  = 64,
    parameter int K_LEN      = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  flush,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [ACC_WIDTH-1:0]  acc_data,
    output logic                  acc_sat,
    output logic                  acc_valid,
    input  logic                  acc_ready
);

    localparam int                 c_cnt_w   = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam int                 c_sum_w   = ACC_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(K_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_sat_s;
    logic [ACC_WIDTH-1:0] r_acc_data;
    logic                 r_acc_sat;
    logic                 r_acc_valid;

    logic [c_sum_w-1:0]   w_sum;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_sum_sat;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_take;

    // The carry out of the widened add is the overflow; an all-ones partial
    // sum plus any nonzero term carries, so saturation is self-sustaining.
    always_comb begin
        w_sum     = {1'b0, r_acc} + c_sum_w'(prod_data);
        w_ovf     = w_sum[ACC_WIDTH];
        w_sum_sat = w_ovf ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
    end

    // Only the final term can be blocked, and only by an undrained result.
    assign w_last  = (r_cnt == c_last);
    assign w_ready = ~flush & ~(w_last & r_acc_valid & ~acc_ready);
    assign w_take  = prod_valid & w_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat_s <= 1'b0;
        end else if (flush) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat_s <= 1'b0;
        end else if (w_take) begin
            if (w_last) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_sat_s <= 1'b0;
            end else begin
                r_acc   <= w_sum_sat;
                r_cnt   <= r_cnt + c_cnt_one;
                r_sat_s <= r_sat_s | w_ovf;
            end
        end
    end

    // A load on the same edge as a drain keeps valid high with no bubble.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc_data  <= '0;
            r_acc_sat   <= 1'b0;
            r_acc_valid <= 1'b0;
        end else if (w_take && w_last) begin
            r_acc_data  <= w_sum_sat;
            r_acc_sat   <= r_sat_s | w_ovf;
            r_acc_valid <= 1'b1;
        end else if (r_acc_valid && acc_ready) begin
            r_acc_valid <= 1'b0;
        end
    end

    assign prod_ready = w_ready;
    assign acc_data   = r_acc_data;
    assign acc_sat    = r_acc_sat;
    assign acc_valid  = r_acc_valid;

endmodule
`default_nettype wire
